// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU-side interrupt bus between the controller and its host
interface irq_controller_if;
  logic [2:0] btn;
  logic       ie;
  logic       ack;
  logic       eret;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [2:0] irw;
  logic [2:0] isr;
  modport master (output btn, ie, ack, eret, input irq_req, irq_id, irw, isr);
  modport slave (input btn, ie, ack, eret, output irq_req, irq_id, irw, isr);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: debounced 3-line push-button interrupt controller with fixed-priority nesting
module irq_controller #(
  parameter int DEBOUNCE = 20
) (
  input  logic             clk,
  input  logic             rst,
  irq_controller_if.slave  bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [2:0]    r_s1, r_s2, r_stable, r_stable_d, r_irw, r_isr;
  logic [CW-1:0] r_cnt [3];
  logic          r_req;
  logic [1:0]    r_id;
  logic [1:0]    w_p, w_s;
  logic          w_req;
  logic [2:0]    w_rise, w_ackm, w_eretm;
  // priority encode pending and in-service sets, decide the next request and the ack/eret masks
  always_comb begin
    w_p     = r_irw[2] ? 2'd2 : r_irw[1] ? 2'd1 : 2'd0;
    w_s     = r_isr[2] ? 2'd2 : r_isr[1] ? 2'd1 : 2'd0;
    w_req   = bus.ie && (|r_irw) && (~|r_isr || w_p > w_s);
    w_rise  = r_stable & ~r_stable_d;
    w_ackm  = (bus.ack && r_req) ? 3'b001 << r_id : 3'b000;
    w_eretm = !bus.eret ? 3'b000 : r_isr[2] ? 3'b100 : r_isr[1] ? 3'b010 : r_isr[0] ? 3'b001 : 3'b000;
  end
  // synchronize, debounce, latch rising edges as pending, and track in-service lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_irw      <= '0;
      r_isr      <= '0;
      r_req      <= 1'b0;
      r_id       <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= bus.btn;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      r_irw <= (r_irw & ~w_ackm) | w_rise;
      r_isr <= (r_isr & ~w_eretm) | w_ackm;
      r_req <= w_req;
      r_id  <= w_req ? w_p : 2'd0;
    end
  end
  assign bus.irq_req = r_req;
  assign bus.irq_id  = r_id;
  assign bus.irw     = r_irw;
  assign bus.isr     = r_isr;
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE, default 20, the number of consecutive clk cycles a synchronized button level must persist before it is accepted (legal range 1..65535).
REQ-002 The port clk SHALL be input, 1 bit: the single CPU-domain clock; all state SHALL update on its rising edge.
REQ-003 The port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-004 The port btn SHALL be input, 3 bits: raw asynchronous push-button interrupt sources, active-high, with line 2 highest priority and line 0 lowest.
REQ-005 The port ie SHALL be input, 1 bit: global interrupt enable from the CPU.
REQ-006 The port ack SHALL be input, 1 bit: a one-cycle pulse from the CPU accepting the currently presented request.
REQ-007 The port eret SHALL be input, 1 bit: a one-cycle pulse from the CPU on return from a handler.
REQ-008 The port irq_req SHALL be output, 1 bit, registered: interrupt request to the CPU.
REQ-009 The port irq_id SHALL be output, 2 bits, registered: the index of the presented line, valid only while irq_req=1.
REQ-010 The port irw SHALL be output, 3 bits, registered: per-line pending ("waiting") flags, driven to LEDs.
REQ-011 The port isr SHALL be output, 3 bits, registered: per-line in-service flags.

Function
REQ-012 Each btn line SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each line SHALL keep a stable level and a counter; the counter SHALL be cleared whenever the synchronized level equals the stable level and SHALL otherwise increment.
REQ-014 The stable level SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE, and the counter SHALL clear on that same edge; the counter width SHALL be sufficient for DEBOUNCE without wrap.
REQ-015 A 0->1 transition of a stable level SHALL set that line's irw bit on the following edge; a 1->0 transition SHALL have no effect.
REQ-016 Priority SHALL be fixed: line 2 over line 1 over line 0. Let P be the highest set irw bit and S the highest set isr bit.
REQ-017 irq_req SHALL be registered as ie AND (irw != 0) AND (isr == 0 OR P > S); irq_id SHALL be registered as P when irq_req=1 and as 0 otherwise.
REQ-018 When ack=1 and irq_req=1, the block SHALL on that edge clear irw[irq_id] and set isr[irq_id]; irq_req SHALL then be recomputed from the updated state on the next edge.
REQ-019 When ack=1 and irq_req=0, ack SHALL be ignored.
REQ-020 When eret=1, the block SHALL clear the highest set isr bit, evaluated from the pre-edge isr value; when eret=1 and isr=0, eret SHALL be ignored.
REQ-021 When ack and eret occur in the same cycle, both SHALL apply: eret clears the pre-edge highest isr bit and ack sets isr[irq_id].
REQ-022 When a new rising edge on line k coincides with ack clearing irw[k], irw[k] SHALL remain 1 (set wins).
REQ-023 A repeat edge on a line whose irw bit is already 1 SHALL be absorbed (no count, no overflow).
REQ-024 ie=0 SHALL suppress irq_req only; irw and isr SHALL continue to update normally.
REQ-025 Latency: a clean btn rise sampled at edge t0 SHALL produce stable=1 at edge t0+1+DEBOUNCE, irw=1 at edge t0+2+DEBOUNCE, and irq_req=1 at edge t0+3+DEBOUNCE (with ie=1 and the priority condition met).

Reset
REQ-026 With rst=1 at a clk edge, the synchronizers, stable levels, counters, irw, isr, irq_req, and irq_id SHALL all become 0, and rst SHALL take precedence over every other input.
REQ-027 A button held high through reset SHALL debounce after rst deasserts and SHALL generate exactly one pending interrupt.

Verification
REQ-028 With DEBOUNCE=4 and ie=1, raise btn[0] at t0 -> irw=001 at edge t0+6 and irq_req=1, irq_id=0 at edge t0+7.
REQ-029 Pulse btn[1] high for 3 cycles with DEBOUNCE=4 -> irw remains 000 and irq_req stays 0.
REQ-030 Set irw=001 and accept with ack, so that isr=001; then raise btn[2] -> irq_req=1 with irq_id=2 (nesting); after ack, isr=101; after eret, isr=001; after a second eret, isr=000.
REQ-031 Set irw=011 with isr=010 -> irq_req=0 (line 0 is lower than the in-service line and line 1 is not higher than itself); after eret, irq_req=1 with irq_id=1.
REQ-032 Drive ack and eret in the same cycle with isr=001 and irq_id=2 -> isr=100; drive ack with irq_req=0 -> no state change.
REQ-033 Assert rst mid-debounce with irw=110 and isr=001 -> all outputs are 0 on the next edge, and no irq_req is generated until a fresh debounced edge occurs.
